// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and a sequential shift-add multiplier.
// Define ALU_SHIFT_EN to add SLL (0011) and SRL (0100).
module alu_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SH_W  = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_take;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic               w_ovf;

    assign in_ready_o  = (r_state == IDLE) && (!r_out_valid || out_ready_i);
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_take      = r_out_valid && out_ready_i;
    assign out_valid_o = r_out_valid;
    assign result_o    = r_result;
    assign zero_o      = r_zero;
    assign cout_o      = r_cout;
    assign overflow_o  = r_ovf;
    assign busy_o      = (r_state == MUL);

    // SUB shares the adder form A + ~B + 1 so its carry means "no borrow".
    assign w_add     = {1'b0, src1_i} + {1'b0, src2_i};
    assign w_sub     = {1'b0, src1_i} + {1'b0, ~src2_i} + {{WIDTH{1'b0}}, 1'b1};
    assign w_add_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (w_add[WIDTH-1] != src1_i[WIDTH-1]);
    assign w_sub_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (w_sub[WIDTH-1] != src1_i[WIDTH-1]);

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (ctrl_i)
            4'b0000: w_res = src1_i & src2_i;
            4'b0001: w_res = src1_i | src2_i;
            4'b0010: begin
                w_res  = w_add[WIDTH-1:0];
                w_cout = w_add[WIDTH];
                w_ovf  = w_add_ovf;
            end
            4'b0110: begin
                w_res  = w_sub[WIDTH-1:0];
                w_cout = w_sub[WIDTH];
                w_ovf  = w_sub_ovf;
            end
            4'b0111: w_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
            4'b1100: w_res = ~(src1_i | src2_i);
            4'b1101: w_res = ~(src1_i & src2_i);
`ifdef ALU_SHIFT_EN
            4'b0011: w_res = src1_i << src2_i[SH_W-1:0];
            4'b0100: w_res = src1_i >> src2_i[SH_W-1:0];
`endif
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mplier    <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept && ctrl_i == OP_MUL) begin
                    r_state  <= MUL;
                    r_mplier <= src2_i;
                    r_mcand  <= {{WIDTH{1'b0}}, src1_i};
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mplier <= r_mplier >> 1;
                    r_mcand  <= r_mcand << 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // The output register is free in DONE because MUL is only accepted when it is.
            if (r_state == DONE) begin
                r_out_valid <= 1'b1;
                r_result    <= r_acc[WIDTH-1:0];
                r_zero      <= (r_acc[WIDTH-1:0] == '0);
                r_cout      <= |r_acc[2*WIDTH-1:WIDTH];
                r_ovf       <= |r_acc[2*WIDTH-1:WIDTH];
            end else if (w_accept && ctrl_i != OP_MUL) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_zero      <= (w_res == '0);
                r_cout      <= w_cout;
                r_ovf       <= w_ovf;
            end else if (w_take) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
